forward_hazard_unit: RTL and testbench

- Produces forwardA/forwardB selects and load-use stall control for the 5-stage RISC-V pipeline.
- Consumes the same 2-bit select encoding as the execute stage:
  - 2'b00 = register-file value
  - 2'b10 = EX/MEM result
  - 2'b01 = MEM/WB result
- Keeps its own shadow pipeline of rs/rd/control fields for the ID/EX, EX/MEM and MEM/WB stages. It needs only ID-stage decode fields plus branch-flush input.

---
 rtl/forward_hazard_unit_if.sv | 38 +++
 rtl/forward_hazard_unit.sv | 132 +++++++++++++
 tb/tb_forward_hazard_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/forward_hazard_unit_if.sv
// rtl/forward_hazard_unit_if.sv - ID-stage decode/flush inputs and forward/stall outputs of the hazard unit
interface forward_hazard_unit_if #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int CNT_BITWIDTH     = 16
);
    logic                        id_valid;
    logic [REG_NUM_BITWIDTH-1:0] id_rs1;
    logic [REG_NUM_BITWIDTH-1:0] id_rs2;
    logic                        id_use_rs1;
    logic                        id_use_rs2;
    logic [REG_NUM_BITWIDTH-1:0] id_rd;
    logic                        id_reg_write;
    logic                        id_mem_read;
    logic                        flush;

    logic [1:0]                  forwardA;
    logic [1:0]                  forwardB;
    logic                        stall;
    logic                        pc_write;
    logic                        ifid_write;
    logic [CNT_BITWIDTH-1:0]     stall_count;
    logic [CNT_BITWIDTH-1:0]     flush_count;

    // Pipeline control side: presents decode fields, consumes selects/stall.
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, flush,
        input  forwardA, forwardB, stall, pc_write, ifid_write,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, flush,
        output forwardA, forwardB, stall, pc_write, ifid_write,
               stall_count, flush_count
    );
endinterface

// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - forwarding selects and load-use stall from a shadow EX/MEM/WB pipeline
module forward_hazard_unit #(
    parameter int REG_NUM_BITWIDTH = 5,
    parameter int CNT_BITWIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    forward_hazard_unit_if.slave  bus
);
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    typedef logic [REG_NUM_BITWIDTH-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rs1;
        reg_idx_t rs2;
        logic     use_rs1;
        logic     use_rs2;
        reg_idx_t rd;
        logic     reg_write;
        logic     mem_read;
    } ex_stage_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     reg_write;
    } wr_stage_t;

    ex_stage_t ex_q,  ex_d;
    wr_stage_t mem_q, mem_d;
    wr_stage_t wb_q,  wb_d;

    logic [CNT_BITWIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_BITWIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic stall;

    // x0 is hardwired zero, so a write to it is never a real producer.
    function automatic logic writes_reg(input wr_stage_t s, input reg_idx_t x);
        return s.valid && s.reg_write && (s.rd != '0) && (s.rd == x);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic use_op, input reg_idx_t src,
                                           input wr_stage_t mem_s, input wr_stage_t wb_s);
        logic [1:0] sel;
        sel = FWD_RF;
        if (use_op) begin
            if (writes_reg(mem_s, src)) begin
                sel = FWD_MEM;
            end else if (writes_reg(wb_s, src)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    always_comb begin
        bus.forwardA = FWD_RF;
        bus.forwardB = FWD_RF;
        if (ex_q.valid) begin
            bus.forwardA = fwd_sel(ex_q.use_rs1, ex_q.rs1, mem_q, wb_q);
            bus.forwardB = fwd_sel(ex_q.use_rs2, ex_q.rs2, mem_q, wb_q);
        end
    end

    // Stall depends only on ID inputs, flush and the registered EX shadow.
    always_comb begin
        load_use = 1'b0;
        if (bus.id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write && (ex_q.rd != '0)) begin
            load_use = (bus.id_use_rs1 && (bus.id_rs1 == ex_q.rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == ex_q.rd));
        end
        stall = load_use && !bus.flush;
    end

    assign bus.stall       = stall;
    assign bus.pc_write    = ~stall;
    assign bus.ifid_write  = ~stall;
    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;

    always_comb begin
        ex_d = '0;
        if (!(stall || bus.flush)) begin
            ex_d.valid     = bus.id_valid;
            ex_d.rs1       = bus.id_rs1;
            ex_d.rs2       = bus.id_rs2;
            ex_d.use_rs1   = bus.id_use_rs1;
            ex_d.use_rs2   = bus.id_use_rs2;
            ex_d.rd        = bus.id_rd;
            ex_d.reg_write = bus.id_reg_write;
            ex_d.mem_read  = bus.id_mem_read;
        end
        mem_d.valid     = ex_q.valid;
        mem_d.rd        = ex_q.rd;
        mem_d.reg_write = ex_q.reg_write;
        wb_d            = mem_q;
    end

    // Event counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_BITWIDTH'(1);
        end
        if (bus.flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_BITWIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb/tb_forward_hazard_unit.sv - directed scoreboard bench for forward_hazard_unit
module tb_forward_hazard_unit;
    logic clk = 1'b0;
    logic rst_n;

    forward_hazard_unit_if #(.REG_NUM_BITWIDTH(5), .CNT_BITWIDTH(16)) bus ();

    forward_hazard_unit #(.REG_NUM_BITWIDTH(5), .CNT_BITWIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    int   failed = 0;
    int   step_n = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_use_rs1   = u1;
        bus.id_use_rs2   = u2;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.flush        = fl;
    endtask

    // One cycle: drive ID after the edge, queue the expected outputs, compare at negedge.
    task automatic step(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic fl,
                        input logic [1:0] efa, input logic [1:0] efb, input logic est);
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        drive(v, rs1, rs2, u1, u2, rd, rw, mr, fl);
        step_n++;
        e.fa = efa; e.fb = efb; e.st = est;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check($sformatf("s%0d_queue", step_n), 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check($sformatf("s%0d_fwdA", step_n), 32'(bus.forwardA), 32'(got.fa));
            check($sformatf("s%0d_fwdB", step_n), 32'(bus.forwardB), 32'(got.fb));
            check($sformatf("s%0d_stall", step_n), 32'(bus.stall), 32'(got.st));
            check($sformatf("s%0d_pcw", step_n), 32'(bus.pc_write), 32'(!got.st));
            check($sformatf("s%0d_ifidw", step_n), 32'(bus.ifid_write), 32'(!got.st));
        end
    endtask

    task automatic nop(input logic [1:0] efa, input logic [1:0] efb);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, efa, efb, 1'b0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [1:0] efa, input logic [1:0] efb, input logic est);
        step(1'b1, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, efa, efb, est);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_fwdA"}, 32'(bus.forwardA), 32'd0);
        check({tag, "_fwdB"}, 32'(bus.forwardB), 32'd0);
        check({tag, "_stall"}, 32'(bus.stall), 32'd0);
        check({tag, "_pcw"}, 32'(bus.pc_write), 32'd1);
        check({tag, "_ifidw"}, 32'(bus.ifid_write), 32'd1);
        check({tag, "_scnt"}, 32'(bus.stall_count), 32'd0);
        check({tag, "_fcnt"}, 32'(bus.flush_count), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #3 check_reset_outputs("por");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Back-to-back ALU dependency; first instruction after reset sees 00.
        alu(5'd5, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0);
        alu(5'd6, 5'd5, 5'd7, 2'b00, 2'b00, 1'b0);
        nop(2'b10, 2'b00);
        // Distance-2 dependency through WB.
        alu(5'd5, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0);
        nop(2'b00, 2'b00);
        alu(5'd8, 5'd5, 5'd5, 2'b00, 2'b00, 1'b0);
        nop(2'b01, 2'b01);
        // Both MEM and WB write x5: the newer MEM value wins.
        alu(5'd5, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0);
        alu(5'd5, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0);
        alu(5'd9, 5'd5, 5'd0, 2'b00, 2'b00, 1'b0);
        nop(2'b10, 2'b00);
        // Load-use: one stall cycle, bubble, then the load is in MEM/WB.
        step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        alu(5'd4, 5'd3, 5'd2, 2'b00, 2'b00, 1'b1);
        alu(5'd4, 5'd3, 5'd2, 2'b00, 2'b00, 1'b0);
        check("lu_scnt", 32'(bus.stall_count), 32'd1);
        nop(2'b01, 2'b00);
        // x0 destination never forwards.
        alu(5'd0, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0);
        alu(5'd6, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0);
        nop(2'b00, 2'b00);
        // jal after a load: operands unused, so no stall despite rs1 match.
        step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b1, 5'd3, 5'd3, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        nop(2'b00, 2'b00);
        // Flush beats load-use; the load in EX also reads x1 from jal in WB.
        step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0);
        nop(2'b00, 2'b00);
        check("fl_fcnt", 32'(bus.flush_count), 32'd1);
        check("fl_scnt", 32'(bus.stall_count), 32'd1);

        // Asynchronous reset while a forward is active.
        alu(5'd5, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0);
        alu(5'd6, 5'd5, 5'd7, 2'b00, 2'b00, 1'b0);
        alu(5'd10, 5'd5, 5'd5, 2'b10, 2'b00, 1'b0);
        #2 rst_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 check_reset_outputs("mid");
        @(negedge clk);
        #2 rst_n = 1'b1;
        alu(5'd11, 5'd10, 5'd5, 2'b00, 2'b00, 1'b0);
        nop(2'b00, 2'b00);

        // Flush counter saturates at all-ones.
        @(posedge clk);
        #1 drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        check("sat_fcnt", 32'(bus.flush_count), 32'hffff);
        check("sat_scnt", 32'(bus.stall_count), 32'd0);
        check("sat_stall", 32'(bus.stall), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
